// File: rtl/shift_rnd_pipe.sv
// Two-stage per-lane scaler: arithmetic right shift with selectable rounding,
// symmetric clamp to width_o, per-lane flags and a saturating saturation counter.
module shift_rnd_pipe #(
  parameter  int width_i     = 9,
  parameter  int width_o     = 8,
  parameter  int lanes       = 4,
  parameter  int cnt_w       = 16,
  localparam int width_shift = $clog2(width_i + 2),
  localparam int width_diff  = width_i - width_o
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [lanes*width_i-1:0]     i_num,
  input  logic [lanes*width_shift-1:0] i_shift,
  input  logic [1:0]                   i_mode,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [lanes*width_o-1:0]     o_rnd,
  output logic [lanes-1:0]             o_sat,
  output logic [lanes-1:0]             o_inexact,
  input  logic                         i_clr,
  output logic [cnt_w-1:0]             o_sat_cnt
);

  localparam int pc_w = $clog2(lanes + 1);
  localparam logic [width_shift-1:0] flush_lim = width_shift'(width_o);
  localparam logic signed [width_i:0] max_pos_w = (width_i+1)'(2**(width_o-1) - 1);
  localparam logic signed [width_o-1:0] pos_code = width_o'(2**(width_o-1) - 1);
  localparam logic signed [width_o-1:0] neg_code = -pos_code;

  logic       s1_valid;
  logic [1:0] s1_mode;
  logic       adv1, adv2, xfer;

  // Stage 2 is the output register, so it frees up whenever the consumer takes it.
  assign adv2    = ~o_valid | i_ready;
  assign adv1    = ~s1_valid | adv2;
  assign o_ready = adv1;
  assign xfer    = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 2'd0;
      o_valid  <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= i_valid;
        s1_mode  <= i_mode;
      end
      if (adv2) o_valid <= s1_valid;
    end
  end

  for (genvar k = 0; k < lanes; k++) begin : g_lane
    logic signed [width_i-1:0]   num;
    logic [width_shift-1:0]      sh;
    logic [width_shift:0]        tot;
    logic signed [2*width_i-1:0] ext_sh;
    logic signed [width_i-1:0]   q1;
    logic                        g1, st1, fl1, nz1;
    logic                        neg, inc, hi, lo;
    logic signed [width_i:0]     r;
    logic signed [width_o-1:0]   rnd_d, rnd2;
    logic                        sat_d, inex_d, sat2, inex2;

    // Appending width_i zero bits keeps every shifted-out bit, so the upper half
    // is the floor quotient and the lower half holds guard and sticky.
    assign num    = $signed(i_num[k*width_i +: width_i]);
    assign sh     = i_shift[k*width_shift +: width_shift];
    assign tot    = {1'b0, sh} + (width_shift+1)'(width_diff);
    assign ext_sh = $signed({num, {width_i{1'b0}}}) >>> tot;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        q1  <= '0;
        g1  <= 1'b0;
        st1 <= 1'b0;
        fl1 <= 1'b0;
        nz1 <= 1'b0;
      end else if (adv1) begin
        q1  <= ext_sh[2*width_i-1 -: width_i];
        g1  <= ext_sh[width_i-1];
        st1 <= |ext_sh[width_i-2:0];
        fl1 <= (sh > flush_lim);
        nz1 <= |num;
      end
    end

    // The quotient is already floored, so each mode only decides whether to add one.
    always_comb begin
      neg = q1[width_i-1];
      case (s1_mode)
        2'd0:    inc = g1 & (st1 | q1[0]);
        2'd1:    inc = neg & (g1 | st1);
        2'd2:    inc = 1'b0;
        default: inc = g1 & (st1 | ~neg);
      endcase
      r      = {q1[width_i-1], q1} + (width_i+1)'(inc);
      hi     = r > max_pos_w;
      lo     = r < -max_pos_w;
      sat_d  = ~fl1 & (hi | lo);
      inex_d = fl1 ? nz1 : (g1 | st1 | hi | lo);
      if (fl1)     rnd_d = '0;
      else if (hi) rnd_d = pos_code;
      else if (lo) rnd_d = neg_code;
      else         rnd_d = r[width_o-1:0];
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        rnd2  <= '0;
        sat2  <= 1'b0;
        inex2 <= 1'b0;
      end else if (adv2) begin
        rnd2  <= rnd_d;
        sat2  <= sat_d;
        inex2 <= inex_d;
      end
    end

    assign o_rnd[k*width_o +: width_o] = rnd2;
    assign o_sat[k]     = sat2;
    assign o_inexact[k] = inex2;
  end

  logic [pc_w-1:0] pc;
  logic [cnt_w:0]  sum;

  always_comb begin
    pc = '0;
    for (int k = 0; k < lanes; k++) pc = pc + pc_w'(o_sat[k]);
  end

  assign sum = {1'b0, o_sat_cnt} + (cnt_w+1)'(pc);

  // A clear that coincides with a transfer still counts that transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst)        o_sat_cnt <= '0;
    else if (i_clr)   o_sat_cnt <= xfer ? cnt_w'(pc) : '0;
    else if (xfer)    o_sat_cnt <= sum[cnt_w] ? '1 : sum[cnt_w-1:0];
  end

endmodule

// File: doc/shift_rnd_pipe.md
SHIFT_RND_PIPE -- requirements
Module: shift_rnd_pipe

Interface
REQ-001 SHALL have parameter width_i, default 9, the signed input element width.
REQ-002 SHALL have parameter width_o, default 8, the signed output element width; width_o < width_i.
REQ-003 SHALL have parameter lanes, default 4, the number of independent elements per beat.
REQ-004 SHALL have parameter cnt_w, default 16, the saturation counter width.
REQ-005 SHALL derive width_shift = $clog2(width_i+2) and width_diff = width_i - width_o.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 Ports (name, direction, width, meaning):
 i_clk  in  1  clock, rising edge
 i_rst  in  1  synchronous active-high reset
 i_valid  in  1  input beat valid
 o_ready  out  1  block can accept a beat this cycle
 i_num  in  lanes*width_i  packed signed elements; lane k at [k*width_i +: width_i]
 i_shift  in  lanes*width_shift  packed unsigned per-lane right shift
 i_mode  in  2  rounding mode for this beat: 0 RNE, 1 RTZ, 2 RDN (floor), 3 RNA
 o_valid  out  1  output beat valid
 i_ready  in  1  downstream accepts output
 o_rnd  out  lanes*width_o  packed signed rounded results
 o_sat  out  lanes  per-lane saturation flag
 o_inexact  out  lanes  per-lane inexact flag
 i_clr  in  1  clear saturation counter
 o_sat_cnt  out  cnt_w  saturating count of saturated lanes

Function
REQ-008 Per lane: exact value v = i_num / 2^(i_shift + width_diff); result = v rounded by i_mode, then clamped.
REQ-009 RNE: nearest, ties to even. RTZ: toward zero. RDN: toward minus infinity. RNA: nearest, ties away from zero.
REQ-010 Clamp range is symmetric: max_pos = 2^(width_o-1)-1, max_neg = -max_pos; the code -2^(width_o-1) is never produced.
REQ-011 o_sat SHALL be 1 iff the rounded value lies outside [max_neg, max_pos].
REQ-012 If i_shift > width_o, the lane result SHALL be 0 in all modes (flush) and o_sat 0.
REQ-013 o_inexact SHALL be 1 iff any discarded bit is nonzero, or o_sat is 1, or a flush discards a nonzero i_num.
REQ-014 i_mode, i_num and i_shift SHALL be sampled together on the accepting edge; a mode change never affects beats already in flight.
REQ-015 Pipeline SHALL be two registered stages: stage 1 = shift plus guard/round/sticky extraction; stage 2 = increment, clamp, flags.
REQ-016 Latency SHALL be exactly 2 cycles from acceptance (i_valid & o_ready) to o_valid, with no stalls.
REQ-017 Throughput SHALL be one beat per cycle while i_ready is held 1.
REQ-018 A stage SHALL advance when it is empty or the next stage advances; o_ready = stage 1 empty or stage 1 advancing (no combinational path from i_valid to o_ready).
REQ-019 While o_valid=1 and i_ready=0, o_rnd, o_sat and o_inexact SHALL hold stable; no beat is dropped or duplicated.
REQ-020 Beats SHALL leave in acceptance order.
REQ-021 o_sat_cnt SHALL add popcount(o_sat) on each output transfer (o_valid & i_ready), saturating at 2^cnt_w-1.
REQ-022 If i_clr and a transfer coincide, the counter SHALL load popcount(o_sat) of that transfer, not 0.

Reset
REQ-023 On i_rst, both stage valids, o_valid, o_rnd, o_sat, o_inexact and o_sat_cnt SHALL be 0; o_ready SHALL be 1 in the first cycle after reset.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight beats; no o_valid may follow from beats accepted before reset.
REQ-025 i_rst SHALL take priority over i_clr and over all handshakes.

Verification
REQ-026 Modes, defaults, lane 0, shift=1: i_num=6 -> RNE 2, RTZ 1, RDN 1, RNA 2; i_num=-6 -> RNE -2, RTZ -1, RDN -2, RNA -2; i_num=10 -> RNE 2, RNA 3; all inexact=1.
REQ-027 Saturation: i_num=255, shift=0, RNE -> o_rnd=127, o_sat=1; i_num=-256, shift=0 -> o_rnd=-127, o_sat=1; o_sat_cnt +2 after both transfers.
REQ-028 Flush: shift=9, i_num=-200, RDN -> o_rnd=0, o_sat=0, o_inexact=1; i_num=0 shift=9 -> o_inexact=0.
REQ-029 Backpressure: stream 10 beats back-to-back, i_ready low for 3 cycles mid-stream -> o_ready falls after both stages fill; all 10 results in order, outputs stable while stalled.
REQ-030 Reset mid-stream: assert i_rst with both stages full -> next cycle o_valid=0, o_sat_cnt=0, o_ready=1; none of the pre-reset beats emerge.
REQ-031 Counter: cnt_w=4, drive 20 saturating lanes -> o_sat_cnt holds 15; i_clr with a 2-saturated-lane transfer -> 2.
